bin_stream_adapt: RTL and testbench

BIN_STREAM_ADAPT -- requirements
Module: bin_stream_adapt

---
 rtl/bin_stream_adapt.sv | 200 ++++++++++++++++++++
 tb/tb_bin_stream_adapt.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_stream_adapt.sv
// Streaming frame binarizer: integrates a raster frame into an integral image,
// then emits one threshold bit per pixel (local-mean or global threshold).
module bin_stream_adapt #(
   parameter int unsigned IMG_W = 256,
   parameter int unsigned IMG_H = 256,
   parameter int unsigned PIX_W = 8,
   parameter int unsigned MAX_R = 31,
   localparam int unsigned RW   = $clog2(MAX_R + 1)
) (
   input  logic             bin_clk,
   input  logic             bin_rst,
   input  logic             start,
   input  logic             mode,
   input  logic             invert,
   input  logic [RW-1:0]    thres_length,
   input  logic [PIX_W-1:0] thres_value,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_data,
   output logic             m_last,
   output logic             busy,
   output logic             done,
   output logic [1:0]       condition_led
);

   localparam int unsigned SUM_W  = PIX_W + $clog2(IMG_W) + $clog2(IMG_H);
   localparam int unsigned CMP_W  = SUM_W + PIX_W;
   localparam int unsigned XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned XW1    = XW + 1;
   localparam int unsigned YW1    = YW + 1;
   localparam int unsigned XE     = XW + RW + 1;
   localparam int unsigned YE     = YW + RW + 1;
   localparam int unsigned DEPTH  = IMG_W * IMG_H;
   localparam int unsigned ADW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned AREA_W = XW + YW + 2;

   typedef enum logic [2:0] {
      IDLE, INTEG, THR_RD, THR_CMP, THR_OUT, DONE
   } state_t;

   state_t state, state_nxt;

   logic [XW-1:0]     x_q, x_nxt, x0, x1, xm, cx;
   logic [YW-1:0]     y_q, y_nxt, y0, y1, ym, cy;
   logic [1:0]        rd_ph;
   logic              mode_q, inv_q;
   logic [PIX_W-1:0]  thr_q;
   logic [RW-1:0]     r_q;
   logic              accept_c, out_hs_c, last_c, cv, bit_c;
   logic [ADW-1:0]    rd_addr, cur_addr;
   logic [AREA_W-1:0] area;
   logic [CMP_W-1:0]  prod;
   logic [SUM_W-1:0]  row_acc, row_cur, int_wr, rd_q, acc, sum_c;
   logic              rd_vld;
   logic [PIX_W-1:0]  pix_q;

   logic [SUM_W-1:0]  lb      [IMG_W];
   logic [PIX_W-1:0]  pix_mem [DEPTH];
   logic [SUM_W-1:0]  int_mem [DEPTH];

   assign accept_c = s_valid & s_ready & (state == INTEG);
   assign out_hs_c = (state == THR_OUT) & m_ready;
   assign last_c   = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = INTEG;
         INTEG:   if (accept_c && last_c) state_nxt = THR_RD;
         THR_RD:  if (rd_ph == 2'd3) state_nxt = THR_CMP;
         THR_CMP: state_nxt = THR_OUT;
         THR_OUT: if (m_ready) state_nxt = last_c ? DONE : THR_RD;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge bin_clk) begin
      if (bin_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // Status and handshake outputs registered from the upcoming state
   always_ff @(posedge bin_clk) begin
      if (bin_rst) begin
         s_ready       <= 1'b0;
         m_valid       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         condition_led <= 2'b00;
      end else begin
         s_ready       <= (state_nxt == INTEG);
         m_valid       <= (state_nxt == THR_OUT);
         busy          <= (state_nxt != IDLE);
         done          <= (state_nxt == DONE);
         condition_led <= {(state_nxt == THR_RD) || (state_nxt == THR_CMP) ||
                           (state_nxt == THR_OUT), (state_nxt == INTEG)};
      end
   end

   // Raster position advance
   always_comb begin
      x_nxt = x_q + XW'(1);
      y_nxt = y_q;
      if (x_q == XW'(IMG_W - 1)) begin
         x_nxt = '0;
         y_nxt = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
      end
   end

   // Clamped window, corner addressing and threshold decision
   always_comb begin
      x0 = (XE'(x_q) >= XE'(r_q)) ? XW'(XE'(x_q) - XE'(r_q)) : '0;
      y0 = (YE'(y_q) >= YE'(r_q)) ? YW'(YE'(y_q) - YE'(r_q)) : '0;
      x1 = (XE'(x_q) + XE'(r_q) > XE'(IMG_W - 1)) ? XW'(IMG_W - 1)
                                                  : XW'(XE'(x_q) + XE'(r_q));
      y1 = (YE'(y_q) + YE'(r_q) > YE'(IMG_H - 1)) ? YW'(IMG_H - 1)
                                                  : YW'(YE'(y_q) + YE'(r_q));
      xm = x0 - XW'(1);
      ym = y0 - YW'(1);
      area = AREA_W'(XW1'(x1) - XW1'(x0) + XW1'(1)) *
             AREA_W'(YW1'(y1) - YW1'(y0) + YW1'(1));

      cx = x1;
      cy = y1;
      cv = 1'b1;
      unique case (rd_ph)
         2'd0: begin cx = x1; cy = y1; cv = 1'b1; end
         2'd1: begin cx = x1; cy = ym; cv = (y0 != '0); end
         2'd2: begin cx = xm; cy = y1; cv = (x0 != '0); end
         default: begin cx = xm; cy = ym; cv = (x0 != '0) && (y0 != '0); end
      endcase
      rd_addr  = cv ? ADW'(cy) * ADW'(IMG_W) + ADW'(cx) : '0;
      cur_addr = ADW'(y_q) * ADW'(IMG_W) + ADW'(x_q);

      row_cur = ((x_q == '0) ? '0 : row_acc) + SUM_W'(s_data);
      int_wr  = ((y_q == '0) ? '0 : lb[x_q]) + row_cur;

      // Modular arithmetic is exact here since the true window sum fits SUM_W
      sum_c = acc + (rd_vld ? rd_q : '0);
      prod  = CMP_W'(pix_q) * CMP_W'(area);
      bit_c = (mode_q ? (pix_q >= thr_q) : (prod >= CMP_W'(sum_c))) ^ inv_q;
   end

   // Control registers, counters and output data
   always_ff @(posedge bin_clk) begin
      if (bin_rst) begin
         x_q    <= '0;
         y_q    <= '0;
         rd_ph  <= '0;
         mode_q <= 1'b0;
         inv_q  <= 1'b0;
         thr_q  <= '0;
         r_q    <= '0;
         m_data <= 1'b0;
         m_last <= 1'b0;
      end else begin
         rd_ph <= (state == THR_RD) ? rd_ph + 2'd1 : 2'd0;
         if ((state == IDLE) && start) begin
            mode_q <= mode;
            inv_q  <= invert;
            thr_q  <= thres_value;
            r_q    <= (thres_length > RW'(MAX_R)) ? RW'(MAX_R) : thres_length;
            x_q    <= '0;
            y_q    <= '0;
         end
         if (accept_c || out_hs_c) begin
            x_q <= x_nxt;
            y_q <= y_nxt;
         end
         if (state == THR_CMP) begin
            m_data <= bit_c;
            m_last <= last_c;
         end
      end
   end

   // Storage and read pipeline; contents survive reset
   always_ff @(posedge bin_clk) begin
      if (accept_c) begin
         pix_mem[cur_addr] <= s_data;
         int_mem[cur_addr] <= int_wr;
         lb[x_q]           <= int_wr;
         row_acc           <= row_cur;
      end
      rd_q   <= int_mem[rd_addr];
      rd_vld <= cv;
      if ((state == THR_RD) && (rd_ph == 2'd0)) pix_q <= pix_mem[cur_addr];
      if (state == THR_RD) begin
         if (rd_ph == 2'd1)      acc <= rd_q;
         else if (rd_ph != 2'd0) acc <= acc - (rd_vld ? rd_q : '0);
      end
   end

endmodule

// File: tb/tb_bin_stream_adapt.sv
// Randomized scoreboard bench for bin_stream_adapt on a 4x4 frame with MAX_R = 2.
module tb_bin_stream_adapt;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 8;
   localparam int MR = 2;
   localparam int RW = 2;
   localparam int N  = W * H;

   logic          bin_clk = 1'b0;
   logic          bin_rst = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic          invert = 1'b0;
   logic [RW-1:0] thres_length = '0;
   logic [PW-1:0] thres_value = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [PW-1:0] s_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          m_data;
   logic          m_last;
   logic          busy;
   logic          done;
   logic [1:0]    condition_led;

   bin_stream_adapt #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .MAX_R(MR)) dut (
      .bin_clk(bin_clk), .bin_rst(bin_rst), .start(start), .mode(mode),
      .invert(invert), .thres_length(thres_length), .thres_value(thres_value),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done), .condition_led(condition_led)
   );

   always #5 bin_clk = ~bin_clk;

   int         tests = 0;
   int         fails = 0;
   logic [1:0] exp_q[$];
   int         pix[N];
   int         hs_cnt = 0;
   int         stall_at = -1;
   int         stall_cnt = 0;
   bit         done_exp = 1'b0;
   bit         idle_exp = 1'b0;
   bit         stall_prev = 1'b0;
   logic       prev_d = 1'b0;
   logic       prev_l = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: direct window sum over the clamped neighbourhood
   function automatic logic model_bit(input int x, input int y, input int r,
                                      input bit md, input bit iv, input int thr);
      int x0, x1, y0, y1, sum, area, p;
      bit b;
      x0 = (x - r < 0) ? 0 : x - r;
      y0 = (y - r < 0) ? 0 : y - r;
      x1 = (x + r > W - 1) ? W - 1 : x + r;
      y1 = (y + r > H - 1) ? H - 1 : y + r;
      sum = 0;
      for (int yy = y0; yy <= y1; yy++)
         for (int xx = x0; xx <= x1; xx++)
            sum += pix[yy * W + xx];
      area = (x1 - x0 + 1) * (y1 - y0 + 1);
      p = pix[y * W + x];
      b = md ? (p >= thr) : (p * area >= sum);
      return b ^ iv;
   endfunction

   // Output monitor: scoreboard pops, stall stability, done timing
   always @(negedge bin_clk) begin
      logic [1:0] e;
      if (stall_prev) begin
         check("stall_valid", int'(m_valid), 1);
         check("stall_data", int'({m_last, m_data}), int'({prev_l, prev_d}));
      end
      stall_prev = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      if (done_exp) begin
         check("done_pulse", int'(done), 1);
         check("busy_in_done", int'(busy), 1);
         done_exp = 1'b0;
         idle_exp = 1'b1;
      end else if (idle_exp) begin
         check("done_clear", int'(done), 0);
         check("busy_clear", int'(busy), 0);
         idle_exp = 1'b0;
      end else if (done) begin
         check("done_spurious", int'(done), 0);
      end
      if (m_valid && m_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got data %0d last %0d, expected none", m_data, m_last);
         end else begin
            e = exp_q.pop_front();
            check("out_bit", int'(m_data), int'(e[0]));
            check("out_last", int'(m_last), int'(e[1]));
         end
         if (m_last) done_exp = 1'b1;
      end
   end

   // m_ready driver: random backpressure plus an armed 20-cycle stall
   always @(posedge bin_clk) begin
      #1;
      if (stall_cnt > 0) begin
         stall_cnt--;
         m_ready = 1'b0;
      end else if (stall_at >= 0 && hs_cnt >= stall_at) begin
         stall_at = -1;
         stall_cnt = 19;
         m_ready = 1'b0;
      end else begin
         m_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check_quiet(input string tag);
      check({tag, "_s_ready"}, int'(s_ready), 0);
      check({tag, "_m_valid"}, int'(m_valid), 0);
      check({tag, "_m_data"}, int'(m_data), 0);
      check({tag, "_m_last"}, int'(m_last), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_led"}, int'(condition_led), 0);
   endtask

   // Called at posedge+1; rst_after > 0 aborts with reset after that many pixels
   task automatic run_frame(input bit md, input bit iv, input int thr,
                            input int rl, input int rst_after);
      int r, n;
      r = (rl > MR) ? MR : rl;
      if (rst_after == 0)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
               exp_q.push_back({(x == W - 1) && (y == H - 1), model_bit(x, y, r, md, iv, thr)});
      start = 1'b1;
      mode = md;
      invert = iv;
      thres_value = PW'(thr);
      thres_length = RW'(rl);
      @(posedge bin_clk); #1;
      start = 1'b0;
      mode = 1'($urandom);
      invert = 1'($urandom);
      thres_value = PW'($urandom);
      thres_length = RW'($urandom);
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(posedge bin_clk); #1;
         end
         s_valid = 1'b1;
         s_data = PW'(pix[i]);
         if (i == 3) start = 1'b1;
         n = 0;
         @(negedge bin_clk);
         while (!s_ready && n < 50) begin
            n++;
            @(negedge bin_clk);
         end
         if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL s_ready_timeout: got 0 after %0d cycles, expected 1", n);
            s_valid = 1'b0;
            exp_q.delete();
            return;
         end
         if (i == 0) begin
            check("led_integ", int'(condition_led), 1);
            check("busy_integ", int'(busy), 1);
         end
         @(posedge bin_clk); #1;
         start = 1'b0;
         if (rst_after == i + 1) begin
            s_valid = 1'b0;
            bin_rst = 1'b1;
            @(posedge bin_clk); #1;
            bin_rst = 1'b0;
            @(negedge bin_clk);
            check_quiet("midrst");
            @(posedge bin_clk); #1;
            return;
         end
      end
      s_valid = 1'b0;
      @(negedge bin_clk);
      check("led_thr", int'(condition_led), 2);
      check("s_ready_thr", int'(s_ready), 0);
      @(posedge bin_clk); #1;
      start = 1'b1;
      @(posedge bin_clk); #1;
      start = 1'b0;
      n = 0;
      do begin
         @(negedge bin_clk);
         n++;
      end while (!done && n < 4000);
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected done", n);
         exp_q.delete();
      end
      @(negedge bin_clk);
      @(negedge bin_clk);
      check("queue_drained", exp_q.size(), 0);
      @(posedge bin_clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge bin_clk);
      @(negedge bin_clk);
      check_quiet("reset");
      @(posedge bin_clk); #1;
      bin_rst = 1'b0;
      @(posedge bin_clk); #1;

      // Flat field, R = 1
      for (int i = 0; i < N; i++) pix[i] = 10;
      run_frame(1'b0, 1'b0, 0, 1, 0);

      // Single bright pixel at (1,1)
      for (int i = 0; i < N; i++) pix[i] = 0;
      pix[1 * W + 1] = 90;
      run_frame(1'b0, 1'b0, 0, 1, 0);

      // Global threshold around 50, both polarities
      for (int i = 0; i < N; i++) pix[i] = $urandom_range(40, 60);
      pix[0] = 49;
      pix[1] = 50;
      pix[2] = 51;
      run_frame(1'b1, 1'b0, 50, 1, 0);
      run_frame(1'b1, 1'b1, 50, 2, 0);

      // R = 0 degenerates to all ones / all zeros
      for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 255);
      run_frame(1'b0, 1'b0, 0, 0, 0);
      run_frame(1'b0, 1'b1, 0, 0, 0);

      // Long downstream stall mid-frame
      for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 255);
      stall_at = hs_cnt + 5;
      run_frame(1'b0, 1'b0, 0, 1, 0);

      // Reset after 7 accepted pixels, then a clean frame
      for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 255);
      run_frame(1'b0, 1'b0, 0, 1, 7);
      for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 255);
      run_frame(1'b0, 1'b0, 0, 1, 0);

      // Radius beyond MAX_R clamps to MAX_R
      for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 255);
      run_frame(1'b0, 1'b0, 0, 3, 0);
      run_frame(1'b0, 1'b0, 0, MR, 0);

      // Random frames
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) pix[i] = $urandom_range(0, 255);
         run_frame(1'($urandom), 1'($urandom), $urandom_range(0, 255),
                   $urandom_range(0, 3), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
